instruction_fetch_unit: RTL and testbench

//   Fetch stage directly downstream of program_counter. Issues instruction-memory reads at the current
//   pc and drives program_counter.clk_enable through pc_advance.

---
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage sitting directly behind program_counter.
// It issues in-order instruction-memory reads at the current pc, tags each read with
// its pc, and buffers returned words in a small FIFO for decode. Credits cover both
// buffered words and reads still in flight, so a returning word always has a slot.
// Redirects (pc_src) flush the FIFO and mark every in-flight read as stale.
// Optional feature: define IFU_PERF_COUNTERS_EN to add fetch_count/stall_count outputs.
module instruction_fetch_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
`ifdef IFU_PERF_COUNTERS_EN
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count,
`endif
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  output logic            pc_advance,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Output FIFO storage: instruction word plus the pc it was fetched from.
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]   fifo_rd;
  logic [PW-1:0]   fifo_wr;
  logic [CW-1:0]   fifo_count;

  // Tag queue: pcs of live (non-stale) reads, in issue order.
  logic [XLEN-1:0] tag_mem [FIFO_DEPTH];
  logic [PW-1:0]   tag_rd;
  logic [PW-1:0]   tag_wr;

  // outstanding counts every read in flight; drop_cnt is how many of those are stale.
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW:0]     occupancy;
  logic            credit_avail;
  logic            accept;
  logic            rsp_live;
  logic            push;
  logic            pop;

  // Request, credit and handshake decode; everything here is purely combinational.
  always_comb begin
    occupancy      = {1'b0, fifo_count} + {1'b0, outstanding};
    credit_avail   = occupancy < {1'b0, DEPTH_C};
    imem_req_valid = !reset && !pc_src && credit_avail;
    imem_req_addr  = pc;
    accept         = imem_req_valid && imem_req_ready;
    pc_advance     = !reset && (accept || pc_src);
    rsp_live       = imem_rsp_valid && (drop_cnt == '0);
    push           = !reset && !pc_src && rsp_live;
    instr_valid    = !reset && (fifo_count != '0);
    pop            = instr_valid && instr_ready;
    instr          = instr_valid ? fifo_data[fifo_rd] : '0;
    instr_pc       = instr_valid ? fifo_pc[fifo_rd]   : '0;
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO on the next edge.
  always_ff @(posedge clk) begin
    if (reset || pc_src) begin
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) fifo_wr <= fifo_wr + 1'b1;
      if (pop)  fifo_rd <= fifo_rd + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO payload write; the returned word is paired with the tag at the queue head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
    end
  end

  // Tag queue pointers; stale tags are simply forgotten on a redirect.
  always_ff @(posedge clk) begin
    if (reset || pc_src) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      if (accept)   tag_wr <= tag_wr + 1'b1;
      if (rsp_live) tag_rd <= tag_rd + 1'b1;
    end
  end

  // Tag payload write: remember the pc of each accepted read.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= pc;
  end

  // In-flight bookkeeping; on a redirect every read still out after this cycle is stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (pc_src)
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  // Performance counters: words handed to decode, and cycles decode had nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop)          fetch_count <= fetch_count + 32'd1;
      if (!instr_valid) stall_count <= stall_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Memory must never return a word that was not requested.
  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0));
  // Credits must keep the FIFO from overflowing.
  assert property (@(posedge clk) disable iff (reset) push |-> ((fifo_count != DEPTH_C) || pop));
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench with a program_counter model and an
// in-order instruction memory model of configurable latency.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_src;
  logic        pc_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instruction_fetch_unit #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef IFU_PERF_COUNTERS_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .pc             (pc),
    .pc_src         (pc_src),
    .pc_advance     (pc_advance),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        instr_ready;
    logic        req_ready;
    logic        exp_req_valid;
    logic        exp_advance;
    logic [31:0] exp_addr;
    logic        exp_instr_valid;
    logic [31:0] exp_instr_pc;
  } vec_t;

  vec_t        vecs [7];
  int          n_vectors = 0;
  int          n_miscompares = 0;

  logic [31:0] pc_model;
  logic [31:0] pc_target;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_data [$];

  logic        s_acc, s_adv, s_pop, s_rsp;
  logic [31:0] s_addr, s_ipc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present pc and any due memory response for the coming cycle.
  task automatic drive_mem();
    pc = pc_model;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Let combinational outputs settle and capture this cycle's handshakes.
  task automatic sample_outputs();
    #1;
    s_acc   = imem_req_valid && imem_req_ready;
    s_adv   = pc_advance;
    s_addr  = imem_req_addr;
    s_pop   = instr_valid && instr_ready;
    s_ipc   = instr_pc;
    s_instr = instr;
    s_rsp   = imem_rsp_valid;
  endtask

  // Advance one clock and update the pc and memory models.
  task automatic apply_stimulus();
    @(posedge clk);
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      pc_model = '0;
    end else begin
      if (s_rsp) begin
        mq_addr.delete(0);
        mq_due.delete(0);
      end
      if (s_pop) begin
        pop_pc.push_back(s_ipc);
        pop_data.push_back(s_instr);
      end
      if (s_adv) pc_model = pc_src ? pc_target : pc_model + 32'd4;
    end
    cyc++;
    if (!reset && s_acc) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + mem_lat - 1);
    end
    @(negedge clk);
    drive_mem();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sample_outputs();
      apply_stimulus();
    end
  endtask

  task automatic do_reset(input int lat);
    reset = 1'b1;
    pc_src = 1'b0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat = lat;
    step(3);
    reset = 1'b0;
    pop_pc.delete();
    pop_data.delete();
  endtask

  task automatic run_until_pops(input string name, input int n, input int budget);
    for (int i = 0; i < budget && pop_pc.size() < n; i++) step(1);
    check_output({name, " pops reached"}, 32'(pop_pc.size() >= n), 32'd1);
  endtask

  task automatic check_pops(input string name, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      check_output($sformatf("%s pop%0d pc", name, k), pop_pc[k], base + 32'(4 * k));
      check_output($sformatf("%s pop%0d data", name, k), pop_data[k], mem_word(base + 32'(4 * k)));
    end
  endtask

  // Two reads in flight, then nflush redirect cycles to target.
  task automatic redirect_test(input string name, input int nflush, input logic [31:0] target);
    do_reset(3);
    instr_ready = 1'b1;
    step(2);
    pc_target = target;
    pc_src = 1'b1;
    for (int f = 0; f < nflush; f++) begin
      sample_outputs();
      check_output($sformatf("%s flush%0d req_valid", name, f), 32'(imem_req_valid), 32'd0);
      check_output($sformatf("%s flush%0d pc_advance", name, f), 32'(pc_advance), 32'd1);
      apply_stimulus();
    end
    pc_src = 1'b0;
    run_until_pops(name, 2, 30);
    check_pops(name, target, 2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Streaming trace from reset with a 1-cycle memory and decode always ready.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h8};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

    reset = 1'b1;
    pc_src = 1'b0;
    pc_target = '0;
    pc_model = '0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    pc = '0;
    @(negedge clk);
    drive_mem();

    $display("[TB] reset behaviour");
    step(4);
    sample_outputs();
    check_output("reset req_valid", 32'(imem_req_valid), 32'd0);
    check_output("reset pc_advance", 32'(pc_advance), 32'd0);
    check_output("reset instr_valid", 32'(instr_valid), 32'd0);
    check_output("reset instr", instr, 32'd0);
    check_output("reset instr_pc", instr_pc, 32'd0);
    apply_stimulus();
    reset = 1'b0;
    pop_pc.delete();
    pop_data.delete();

    $display("[TB] streaming table");
    for (int i = 0; i < 7; i++) begin
      instr_ready = vecs[i].instr_ready;
      imem_req_ready = vecs[i].req_ready;
      sample_outputs();
      check_output($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_req_valid));
      check_output($sformatf("vec%0d pc_advance", i), 32'(pc_advance), 32'(vecs[i].exp_advance));
      check_output($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check_output($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_instr_valid));
      if (vecs[i].exp_instr_valid)
        check_output($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].exp_instr_pc);
      apply_stimulus();
    end
    check_output("stream pop count", 32'(pop_pc.size()), 32'd4);
    check_pops("stream", 32'h0, 4);
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    step(3);
`ifdef IFU_PERF_COUNTERS_EN
    sample_outputs();
    check_output("perf fetch_count", fetch_count, 32'd4);
    check_output("perf stall_count>=3", 32'(stall_count >= 32'd3), 32'd1);
`endif

    $display("[TB] backpressure");
    do_reset(1);
    step(3);
    sample_outputs();
    check_output("bp req_valid", 32'(imem_req_valid), 32'd0);
    check_output("bp pc_advance", 32'(pc_advance), 32'd0);
    check_output("bp instr_valid", 32'(instr_valid), 32'd1);
    check_output("bp instr_pc", instr_pc, 32'h0);
    check_output("bp pc held", imem_req_addr, 32'h8);
    apply_stimulus();
    step(3);
    sample_outputs();
    check_output("bp pc still held", imem_req_addr, 32'h8);
    check_output("bp req_valid still", 32'(imem_req_valid), 32'd0);
    apply_stimulus();
    instr_ready = 1'b1;
    run_until_pops("bp", 6, 40);
    check_pops("bp", 32'h0, 6);

    $display("[TB] redirect");
    redirect_test("redir", 1, 32'h170);
    redirect_test("redir2", 2, 32'h300);

    $display("[TB] flush with response and pop");
    do_reset(1);
    instr_ready = 1'b1;
    step(2);
    pc_target = 32'h200;
    pc_src = 1'b1;
    sample_outputs();
    check_output("fl pop in flush", 32'(instr_valid), 32'd1);
    check_output("fl pc_advance", 32'(pc_advance), 32'd1);
    apply_stimulus();
    pc_src = 1'b0;
    sample_outputs();
    check_output("fl instr_valid +1", 32'(instr_valid), 32'd0);
    check_output("fl req_addr", imem_req_addr, 32'h200);
    apply_stimulus();
    sample_outputs();
    check_output("fl instr_valid +2", 32'(instr_valid), 32'd0);
    apply_stimulus();
    sample_outputs();
    check_output("fl instr_valid +3", 32'(instr_valid), 32'd1);
    check_output("fl instr_pc +3", instr_pc, 32'h200);
    check_output("fl instr +3", instr, mem_word(32'h200));
    check_output("fl pops", 32'(pop_pc.size()), 32'd1);
    check_output("fl flushed pop pc", pop_pc[0], 32'h0);
    apply_stimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
